cds_row_subtract: RTL



---
 rtl/pdshank_pkg.sv | 18 +
 rtl/cds_sig_buf.sv | 27 ++
 rtl/cds_row_subtract.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pdshank_pkg.sv
// Shared definitions for the pixel-shank readout path: word layout, row size, CDS phase.
// Latency: n/a (package).
// Backpressure: n/a.
package pdshank_pkg;

  localparam int IDX_MSB  = 15;
  localparam int IDX_LSB  = 12;
  localparam int FLAG_BIT = 11;
  localparam int DATA_W   = 10;
  localparam int NPIX     = 10;

  // SIG collects the signal half of a row, RST pairs reset words against it.
  typedef enum logic {
    ST_SIG = 1'b0,
    ST_RST = 1'b1
  } cds_state_t;

endpackage

// File: rtl/cds_sig_buf.sv
// Per-pixel signal-sample store: one write port, one combinational read port.
// Latency: write visible the cycle after wr_en, read is combinational.
// Backpressure: none; contents are not reset.
module cds_sig_buf #(
  parameter int NPIX = 10,
  parameter int DW   = 10
) (
  input  logic          clk_in,
  input  logic          wr_en,
  input  logic [3:0]    wr_idx,
  input  logic [DW-1:0] wr_data,
  input  logic [3:0]    rd_idx,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [NPIX];

  // Capture a signal sample into its pixel slot.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/cds_row_subtract.sv
// Correlated double sampling: emits (reset - signal) per pixel as reset words arrive.
// Latency: 1 cycle din_valid -> dout_valid.
// Backpressure: none; fifo_full drops the word, sets err_ovf, sequence keeps advancing.
module cds_row_subtract
  import pdshank_pkg::*;
#(
  parameter int NPIX = pdshank_pkg::NPIX,
  parameter int DW   = pdshank_pkg::DATA_W
) (
  input  logic        clk_in,
  input  logic        cds_rst,
  input  logic [15:0] din,
  input  logic        din_valid,
  input  logic        bypass,
  input  logic        fifo_full,
  input  logic        clear_err,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic [9:0]  row_count,
  output logic [9:0]  frame_count,
  output logic        err_seq,
  output logic        err_ovf
);

  localparam logic [3:0] LAST_IDX = 4'(NPIX - 1);

  cds_state_t    state, state_nxt, eff_state;
  logic [3:0]    exp_idx, exp_nxt, eff_exp;
  logic          resync;     // a bypass episode happened; next CDS word must start a row
  logic          prev_flag;  // frame flag of the last accepted CDS word

  logic [3:0]    idx;
  logic          flag;
  logic [DW-1:0] data;
  logic [DW-1:0] sig_rd;
  logic [DW:0]   diff;

  logic act, match, accepted, buf_we, emit_cds, row_inc, seq_err, frame_start;
  logic out_req, out_go;

  assign idx  = din[IDX_MSB:IDX_LSB];
  assign flag = din[FLAG_BIT];
  assign data = din[DW-1:0];

  // After bypass the row in progress is abandoned: view the FSM as a fresh SIG idx 0.
  assign eff_state = resync ? ST_SIG : state;
  assign eff_exp   = resync ? 4'd0 : exp_idx;

  assign act   = din_valid && !bypass;
  assign match = (idx <= LAST_IDX) && (idx == eff_exp);
  assign diff  = {1'b0, data} - {1'b0, sig_rd};

  cds_sig_buf #(.NPIX(NPIX), .DW(DW)) u_sig_buf (
    .clk_in  (clk_in),
    .wr_en   (buf_we),
    .wr_idx  (idx),
    .wr_data (data),
    .rd_idx  (idx),
    .rd_data (sig_rd)
  );

  // Next-state: phase/index tracking, mismatch recovery and event strobes.
  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_idx;
    buf_we    = 1'b0;
    emit_cds  = 1'b0;
    row_inc   = 1'b0;
    seq_err   = 1'b0;
    accepted  = 1'b0;
    if (act) begin
      if (match) begin
        accepted = 1'b1;
        if (eff_state == ST_SIG) begin
          buf_we = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = ST_RST;
            exp_nxt   = 4'd0;
          end else begin
            state_nxt = ST_SIG;
            exp_nxt   = idx + 4'd1;
          end
        end else begin
          emit_cds = 1'b1;
          if (idx == LAST_IDX) begin
            row_inc   = 1'b1;
            state_nxt = ST_SIG;
            exp_nxt   = 4'd0;
          end else begin
            state_nxt = ST_RST;
            exp_nxt   = idx + 4'd1;
          end
        end
      end else begin
        seq_err   = 1'b1;
        state_nxt = ST_SIG;
        exp_nxt   = 4'd0;
        if (idx == 4'd0) begin
          // Out-of-order idx 0 is taken as the start of a new row.
          accepted = 1'b1;
          buf_we   = 1'b1;
          exp_nxt  = 4'd1;
        end
      end
    end
  end

  assign frame_start = buf_we && (idx == 4'd0) && flag && !prev_flag;
  assign out_req     = emit_cds || (din_valid && bypass);
  assign out_go      = out_req && !fifo_full;

  // FSM registers and bypass resync tracking.
  always_ff @(posedge clk_in) begin
    if (cds_rst) begin
      state     <= ST_SIG;
      exp_idx   <= 4'd0;
      resync    <= 1'b0;
      prev_flag <= 1'b0;
    end else begin
      state   <= state_nxt;
      exp_idx <= exp_nxt;
      if (bypass) begin
        resync <= 1'b1;
      end else if (din_valid) begin
        resync <= 1'b0;
      end
      if (accepted) begin
        prev_flag <= flag;
      end
    end
  end

  // Row/frame counters; a frame start restarts the row count.
  always_ff @(posedge clk_in) begin
    if (cds_rst) begin
      row_count   <= 10'd0;
      frame_count <= 10'd0;
    end else if (frame_start) begin
      frame_count <= frame_count + 10'd1;
      row_count   <= 10'd0;
    end else if (row_inc) begin
      row_count <= row_count + 10'd1;
    end
  end

  // Output register and sticky error flags (a new event beats clear_err).
  always_ff @(posedge clk_in) begin
    if (cds_rst) begin
      dout       <= 16'd0;
      dout_valid <= 1'b0;
      err_seq    <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      dout_valid <= out_go;
      if (out_go) begin
        dout <= bypass ? din : {idx, flag, diff};
      end
      err_seq <= seq_err || (err_seq && !clear_err);
      err_ovf <= (out_req && fifo_full) || (err_ovf && !clear_err);
    end
  end

endmodule
